// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter time-sharing one registered adder among NREQ requesters.
// A grant launches operands, the adder answers one edge later, and the sum returns as a one-cycle pulse.
module adder_share_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      add_in1,
    output logic [WIDTH-1:0]      add_in2,
    input  logic [WIDTH-1:0]      add_out,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   ptr_next;
    logic [IDW-1:0]   win_hi;
    logic [IDW-1:0]   win_lo;
    logic             found_hi;
    logic             found_lo;
    logic             found;
    logic             grant;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Round-robin search: first valid at or above ptr, else the first valid overall (wrap).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && (IDW'(i) >= ptr) && !found_hi) begin
                found_hi = 1'b1;
                win_hi   = IDW'(i);
            end
            if (req_valid[i] && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = IDW'(i);
            end
        end
        found  = found_hi | found_lo;
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign grant    = (state == IDLE) && found;
    assign ptr_next = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs; grants are suppressed while reset is held even if requests are already pending.
    always_comb begin
        req_ready = '0;
        busy      = (state != IDLE);
        if (grant && !reset) begin
            for (int i = 0; i < NREQ; i++) req_ready[i] = (winner == IDW'(i));
        end
    end

    // Operand launch, round-robin pointer and response capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            id        <= '0;
            add_in1   <= '0;
            add_in2   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= (state == CAPTURE);
            if (grant) begin
                add_in1 <= sel_a;
                add_in2 <= sel_b;
                id      <= winner;
                ptr     <= ptr_next;
            end
            if (state == CAPTURE) begin
                rsp_data <= add_out;
                rsp_id   <= id;
            end
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed scenarios on a 2-requester instance, wrap-around and
// randomized traffic on a 4-requester instance, each against a registered adder modelled here.
module tb_adder_share_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [1:0]     v2, rdy2, rid2;
    logic [2*W-1:0] a2, b2;
    logic [W-1:0]   in1_2, in2_2, out2, rd2;
    logic           rv2, busy2;

    logic [3:0]     v4, rdy4;
    logic [1:0]     rid4;
    logic [4*W-1:0] a4, b4;
    logic [W-1:0]   in1_4, in2_4, out4, rd4;
    logic           rv4, busy4;

    int checks = 0;
    int errors = 0;

    adder_share_arbiter #(.NREQ(2), .WIDTH(W), .IDW(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_a(a2), .req_b(b2),
        .req_ready(rdy2), .add_in1(in1_2), .add_in2(in2_2), .add_out(out2),
        .rsp_valid(rv2), .rsp_id(rid2), .rsp_data(rd2), .busy(busy2)
    );

    adder_share_arbiter #(.NREQ(4), .WIDTH(W), .IDW(2)) dut4 (
        .clk(clk), .reset(reset), .req_valid(v4), .req_a(a4), .req_b(b4),
        .req_ready(rdy4), .add_in1(in1_4), .add_in2(in2_4), .add_out(out4),
        .rsp_valid(rv4), .rsp_id(rid4), .rsp_data(rd4), .busy(busy4)
    );

    // Shared adders: one-cycle registered sum
    always_ff @(posedge clk) begin
        out2 <= in1_2 + in2_2;
        out4 <= in1_4 + in2_4;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        v2 = 2'b10; a2 = {32'd5, 32'd0}; b2 = {32'd6, 32'd0};
        v4 = '0; a4 = '0; b4 = '0;
        #1;
        checks++; if (rdy2 !== 2'b00) begin errors++; $display("FAIL reset_ready_gated: got %b want 00", rdy2); end
        step(); step();
        checks++;
        if ({rv2, rid2, rd2, in1_2, in2_2, busy2} !== '0) begin
            errors++; $display("FAIL reset_outputs2: rv=%b id=%0d data=%0h in1=%0h in2=%0h busy=%b want all 0", rv2, rid2, rd2, in1_2, in2_2, busy2);
        end
        checks++;
        if ({rv4, rid4, rd4, in1_4, in2_4, busy4, rdy4} !== '0) begin
            errors++; $display("FAIL reset_outputs4: rv=%b id=%0d data=%0h busy=%b rdy=%b want all 0", rv4, rid4, rd4, busy4, rdy4);
        end
        v2 = 2'b00;
        reset = 1'b0;
        step();
        checks++; if (rdy2 !== 2'b00) begin errors++; $display("FAIL reset_idle_ready: got %b want 00", rdy2); end
        v2 = 2'b10;
        #1;
        checks++; if (rdy2 !== 2'b10) begin errors++; $display("FAIL first_grant_req1: got %b want 10", rdy2); end
        step();
        v2 = 2'b00;
        step(); step();
        checks++;
        if (rv2 !== 1'b1 || rid2 !== 2'd1 || rd2 !== 32'd11) begin
            errors++; $display("FAIL first_rsp: rv=%b id=%0d data=%0d want 1/1/11", rv2, rid2, rd2);
        end
        step();
    endtask

    task automatic test_single();
        v2 = 2'b01; a2 = {32'd0, 32'd2}; b2 = {32'd0, 32'd20};
        #1;
        checks++; if (rdy2 !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", rdy2); end
        step();
        v2 = 2'b00;
        #1;
        checks++;
        if (in1_2 !== 32'd2 || in2_2 !== 32'd20 || busy2 !== 1'b1) begin
            errors++; $display("FAIL single_operands: in1=%0d in2=%0d busy=%b want 2/20/1", in1_2, in2_2, busy2);
        end
        step();
        checks++; if (rv2 !== 1'b0) begin errors++; $display("FAIL single_early_rsp: rv=%b want 0", rv2); end
        step();
        checks++;
        if (rv2 !== 1'b1 || rid2 !== 2'd0 || rd2 !== 32'd22 || busy2 !== 1'b0) begin
            errors++; $display("FAIL single_rsp: rv=%b id=%0d data=%0d busy=%b want 1/0/22/0", rv2, rid2, rd2, busy2);
        end
        step();
        checks++; if (rv2 !== 1'b0) begin errors++; $display("FAIL single_pulse: rv=%b want 0", rv2); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rdy;
        logic       exp_rv;
        int         exp_id;
        reset = 1'b1; #1; reset = 1'b0;
        a2 = {32'd7, 32'd25}; b2 = {32'd3, 32'd5};
        for (int it = 0; it <= 12; it++) begin
            v2 = (it < 12) ? 2'b11 : 2'b00;
            #1;
            exp_rdy = (it % 3 == 0 && it < 12) ? ((((it / 3) % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rv  = (it >= 3 && it % 3 == 0);
            exp_id  = ((it / 3) - 1) % 2;
            checks++; if (rdy2 !== exp_rdy) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", it, rdy2, exp_rdy); end
            checks++; if (rv2 !== exp_rv) begin errors++; $display("FAIL b2b_rv[%0d]: got %b want %b", it, rv2, exp_rv); end
            if (exp_rv) begin
                checks++;
                if (rid2 !== 2'(exp_id) || rd2 !== ((exp_id == 0) ? 32'd30 : 32'd10)) begin
                    errors++; $display("FAIL b2b_rsp[%0d]: id=%0d data=%0d want id %0d", it, rid2, rd2, exp_id);
                end
            end
            step();
        end
    endtask

    task automatic test_carry();
        v2 = 2'b10; a2 = {32'hFFFF_FFFF, 32'd0}; b2 = {32'd1, 32'd0};
        #1;
        checks++; if (rdy2 !== 2'b10) begin errors++; $display("FAIL carry_ready: got %b want 10", rdy2); end
        step();
        v2 = 2'b00;
        #1;
        checks++;
        if (in1_2 !== 32'hFFFF_FFFF || in2_2 !== 32'd1) begin
            errors++; $display("FAIL carry_operands: in1=%0h in2=%0h want ffffffff/1", in1_2, in2_2);
        end
        step(); step();
        checks++;
        if (rv2 !== 1'b1 || rid2 !== 2'd1 || rd2 !== 32'd0) begin
            errors++; $display("FAIL carry_rsp: rv=%b id=%0d data=%0h want 1/1/0", rv2, rid2, rd2);
        end
        step();
        checks++;
        if (rv2 !== 1'b0 || busy2 !== 1'b0 || rdy2 !== 2'b00) begin
            errors++; $display("FAIL carry_after: rv=%b busy=%b rdy=%b want 0/0/00", rv2, busy2, rdy2);
        end
    endtask

    task automatic test_reset_mid();
        v2 = 2'b01; a2 = {32'd0, 32'd100}; b2 = {32'd0, 32'd23};
        #1;
        step();
        v2 = 2'b00;
        step();
        reset = 1'b1;
        #1;
        checks++;
        if ({rv2, rid2, rd2, in1_2, in2_2, busy2, rdy2} !== '0) begin
            errors++; $display("FAIL midreset_outputs: rv=%b id=%0d data=%0h in1=%0h in2=%0h busy=%b rdy=%b want all 0", rv2, rid2, rd2, in1_2, in2_2, busy2, rdy2);
        end
        step(); step();
        reset = 1'b0;
        for (int it = 0; it < 4; it++) begin
            checks++; if (rv2 !== 1'b0) begin errors++; $display("FAIL midreset_no_rsp[%0d]: rv=%b want 0", it, rv2); end
            step();
        end
        v2 = 2'b11;
        #1;
        checks++; if (rdy2 !== 2'b01) begin errors++; $display("FAIL midreset_ptr: rdy=%b want 01", rdy2); end
        step();
        v2 = 2'b00;
        step(); step();
        checks++;
        if (rv2 !== 1'b1 || rid2 !== 2'd0 || rd2 !== 32'd123) begin
            errors++; $display("FAIL midreset_rsp: rv=%b id=%0d data=%0d want 1/0/123", rv2, rid2, rd2);
        end
        step();
    endtask

    task automatic test_wrap4();
        reset = 1'b1; #1; reset = 1'b0;
        v4 = 4'b0010; a4 = '0; b4 = '0;
        a4[63:32] = 32'd10; b4[63:32] = 32'd1;
        #1;
        step();
        v4 = 4'b0000;
        step(); step();
        checks++;
        if (rv4 !== 1'b1 || rid4 !== 2'd1 || rd4 !== 32'd11) begin
            errors++; $display("FAIL wrap_setup_rsp: rv=%b id=%0d data=%0d want 1/1/11", rv4, rid4, rd4);
        end
        v4 = 4'b1010;
        a4[127:96] = 32'd100; b4[127:96] = 32'd3;
        a4[63:32]  = 32'd40;  b4[63:32]  = 32'd2;
        #1;
        checks++; if (rdy4 !== 4'b1000) begin errors++; $display("FAIL wrap_first_grant: rdy=%b want 1000", rdy4); end
        step();
        v4 = 4'b0010;
        #1;
        checks++;
        if (rdy4 !== 4'b0000 || busy4 !== 1'b1) begin
            errors++; $display("FAIL wrap_issue: rdy=%b busy=%b want 0000/1", rdy4, busy4);
        end
        step(); step();
        checks++;
        if (rv4 !== 1'b1 || rid4 !== 2'd3 || rd4 !== 32'd103 || rdy4 !== 4'b0010) begin
            errors++; $display("FAIL wrap_rsp3: rv=%b id=%0d data=%0d rdy=%b want 1/3/103/0010", rv4, rid4, rd4, rdy4);
        end
        step();
        v4 = 4'b0000;
        step(); step();
        checks++;
        if (rv4 !== 1'b1 || rid4 !== 2'd1 || rd4 !== 32'd42) begin
            errors++; $display("FAIL wrap_rsp1: rv=%b id=%0d data=%0d want 1/1/42", rv4, rid4, rd4);
        end
        step();
    endtask

    // Reference model: pending requests per requester, a round-robin pointer, a 3-cycle
    // occupancy window after each grant and the expected response due time.
    task automatic test_random();
        logic         pend [4];
        logic [W-1:0] pa [4];
        logic [W-1:0] pb [4];
        logic [W-1:0] last_a, last_b, exp_data;
        logic [3:0]   exp_rdy;
        int           mptr, left, rsp_due, exp_id, exp_w;
        reset = 1'b1; #1; reset = 1'b0;
        for (int i = 0; i < 4; i++) begin pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
        mptr = 0; left = 0; rsp_due = -1; exp_id = 0; exp_data = '0; last_a = '0; last_b = '0;
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1; pa[i] = $urandom; pb[i] = $urandom;
                end else if (pend[i] && left > 0 && $urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b0;
                end
                v4[i] = pend[i];
                a4[i*W +: W] = pa[i];
                b4[i*W +: W] = pb[i];
            end
            #1;
            exp_w = -1;
            if (left == 0) begin
                for (int k = 0; k < 4; k++) begin
                    int j;
                    j = (mptr + k) % 4;
                    if (exp_w < 0 && pend[j]) exp_w = j;
                end
            end
            exp_rdy = (exp_w >= 0) ? 4'(1 << exp_w) : 4'b0000;
            checks++; if (rv4 !== (rsp_due == it)) begin errors++; $display("FAIL rand_rv[%0d]: got %b want %b", it, rv4, rsp_due == it); end
            if (rsp_due == it) begin
                checks++;
                if (rid4 !== 2'(exp_id) || rd4 !== exp_data) begin
                    errors++; $display("FAIL rand_rsp[%0d]: id=%0d data=%0h want id=%0d data=%0h", it, rid4, rd4, exp_id, exp_data);
                end
            end
            checks++; if (busy4 !== (left > 0)) begin errors++; $display("FAIL rand_busy[%0d]: got %b want %b", it, busy4, left > 0); end
            if (left == 2) begin
                checks++;
                if (in1_4 !== last_a || in2_4 !== last_b) begin
                    errors++; $display("FAIL rand_operands[%0d]: in1=%0h in2=%0h want %0h/%0h", it, in1_4, in2_4, last_a, last_b);
                end
            end
            checks++; if (rdy4 !== exp_rdy) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", it, rdy4, exp_rdy); end
            if (left > 0) begin
                left--;
            end else if (exp_w >= 0) begin
                left     = 2;
                rsp_due  = it + 3;
                exp_id   = exp_w;
                exp_data = pa[exp_w] + pb[exp_w];
                last_a   = pa[exp_w];
                last_b   = pb[exp_w];
                pend[exp_w] = 1'b0;
                mptr     = (exp_w + 1) % 4;
            end
            step();
        end
        v4 = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_carry();
        test_reset_mid();
        test_wrap4();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter that time-shares one registered 32-bit adder (one-cycle latency, result registered on `posedge clk`) among several requesters in the MIPS datapath, e.g. the PC+4 incrementer and the branch-target calculation. It accepts one request at a time through a valid/ready handshake and drives the adder's operand inputs. It captures the adder's output and returns the sum with the requester's ID as a one-cycle response pulse.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `WIDTH`, default 32: operand/result width.
- `IDW`, default 2: ID width, must satisfy 2^IDW >= NREQ.

- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  bit i = requester i has an add pending.
- `req_a`  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B, same packing.
- `req_ready`  out  NREQ  one-hot grant; the request is accepted on the edge where valid & ready.
- `add_in1`  out  WIDTH  registered operand to the shared adder.
- `add_in2`  out  WIDTH  registered operand to the shared adder.
- `add_out`  in  WIDTH  shared adder result, valid one edge after the operands are presented.
- `rsp_valid`  out  1  one-cycle pulse; `rsp_data`/`rsp_id` are valid.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_data`  out  WIDTH  sum, modulo 2^WIDTH.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
- **IDLE**
  - If any `req_valid` is set, the winner is the first set bit found scanning from index `ptr` upward, wrapping at NREQ.
  - `req_ready[winner]` is asserted combinationally in this cycle; all other bits stay 0.
  - At the edge:
    - `add_in1 <= req_a[winner]`, `add_in2 <= req_b[winner]`.
    - `id <= winner`.
    - `ptr <= (winner+1) mod NREQ`.
    - Go to ISSUE.
  - If no request is pending, stay in IDLE with `ptr` unchanged.
- **ISSUE**
  - `add_in1`/`add_in2` are held; the adder samples them at this edge.
  - Go to CAPTURE.
- **CAPTURE**
  - `add_out` now holds the sum.
  - At the edge:
    - `rsp_data <= add_out`, `rsp_id <= id`, `rsp_valid <= 1`.
    - Go to IDLE.
- `rsp_valid` is cleared on the next edge unless a new CAPTURE completes. Back-to-back responses are therefore at least 3 cycles apart.
- `req_ready` is 0 in ISSUE and CAPTURE. A requester holds `req_valid` and operands stable until granted.
  - Dropping `req_valid` before grant is legal and causes no operation.
- Arithmetic: carry out of bit WIDTH-1 is discarded. There is no overflow flag and no signed/unsigned distinction.
- `add_in1`/`add_in2` keep their last values in IDLE; no operation is issued until the next grant.
- Simultaneous events:
  - A grant may occur in the same cycle `rsp_valid` is high, because that cycle is in IDLE.
  - A requester may re-request in the cycle it receives its own response. It wins only if no other valid requester precedes it from `ptr`.

## Timing
- Reset (asynchronous, immediate) forces:
  - state=IDLE, `ptr`=0, `id`=0;
  - `add_in1`=`add_in2`=0;
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0;
  - `req_ready`=0, `busy`=0.
- Reset mid-operation (ISSUE or CAPTURE) abandons the operation; no response is ever produced for it.
- Latency, with the grant edge counted as E0:
  - E0: operands launched.
  - E1: adder computes.
  - E2: response registered.
  - `rsp_valid` is high in the cycle between E2 and E3.
- Throughput: one addition per 3 cycles.
- `busy` is high from just after E0 until E2.

## Test plan
1. Hold `reset`=1, then release. Required: every output 0, `req_ready`=0 until a valid arrives; first request from req1 is granted immediately.
2. NREQ=2; req0 valid with a=2, b=20. Required: `req_ready`=01 in the request cycle; `add_in1`=2, `add_in2`=20 after E0; `rsp_valid`=1, `rsp_id`=0, `rsp_data`=22 after E2; single pulse.
3. Both requesters valid continuously; req0 a=25 b=5, req1 a=7 b=3. Required: grants alternate 0,1,0,1 at 3-cycle spacing; responses (0,30), (1,10), (0,30), …
4. req1 with a=0xFFFFFFFF, b=1. Required: `rsp_data`=0, `rsp_id`=1, no other side effect.
5. Assert `reset` during CAPTURE. Required: all outputs 0 immediately; no `rsp_valid` pulse follows; with req0 and req1 then both valid, req0 is granted first (`ptr`=0).
6. NREQ=4, `ptr`=2, req1 and req3 valid. Required: grant req3 first, then req1 (wrap-around); `rsp_id` sequence 3, 1.
